// File: rtl/weights_pkg.sv
// Shared constants and types for the MLP weight loader.
package weights_pkg;

  localparam int DEF_N1  = 98;
  localparam int DEF_N2  = 10;
  localparam int DEF_W_K = 4;

  localparam int TOTAL_WORDS = DEF_N1 * DEF_N2 + DEF_N2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MAG,
    LOAD_POL,
    LOAD_N2,
    DONE,
    ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    PH_MAG,
    PH_POL,
    PH_N2
  } phase_t;

endpackage

// File: rtl/weights_addr_gen.sv
// Row/column/phase walker for the weight stream: column fastest, then row, then array.
module weights_addr_gen
  import weights_pkg::*;
#(
  parameter int ROWS = DEF_N1 / 2,
  parameter int COLS = DEF_N2,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear,
  input  logic          step,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output phase_t        phase,
  output logic          is_final
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row   <= '0;
      col   <= '0;
      phase <= PH_MAG;
    end else if (clear) begin
      row   <= '0;
      col   <= '0;
      phase <= PH_MAG;
    end else if (step) begin
      if (col == CW'(COLS - 1)) begin
        col <= '0;
        // The layer-2 array is a single row, so row stays at zero there.
        if (phase != PH_N2) begin
          if (row == RW'(ROWS - 1)) begin
            row   <= '0;
            phase <= (phase == PH_MAG) ? PH_POL : PH_N2;
          end else begin
            row <= row + RW'(1);
          end
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  assign is_final = (phase == PH_N2) && (col == CW'(COLS - 1));

endmodule

// File: rtl/weights_loader.sv
// Serial writer for the MLP weight register bank with framing checks.
// Optional WEIGHTS_LOADER_CKSUM_EN adds an 8-bit additive checksum on the final word.
module weights_loader
  import weights_pkg::*;
#(
  parameter int N1  = DEF_N1,
  parameter int N2  = DEF_N2,
  parameter int W_K = DEF_W_K
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [W_K-1:0]                       s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic                                 s_last,
`ifdef WEIGHTS_LOADER_CKSUM_EN
  input  logic [7:0]                           cksum_in,
`endif
  output logic [N1/2-1:0][N2-1:0][W_K-1:0]     weights_n1_mag,
  output logic [N1/2-1:0][N2-1:0][W_K-1:0]     weights_n1_pol,
  output logic [N2-1:0][W_K-1:0]               weights_n2,
  output logic                                 weights_valid,
  output logic                                 busy,
  output logic                                 error
);

  localparam int ROWS = N1 / 2;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW   = (N2 > 1) ? $clog2(N2) : 1;

  loader_state_t state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  phase_t        phase;
  logic          is_final;
  logic          in_load;
  logic          begin_load;
  logic          fire;
  logic          phase_done;
  logic          cksum_ok;

  assign in_load    = (state == LOAD_MAG) || (state == LOAD_POL) || (state == LOAD_N2);
  assign begin_load = start && !in_load;
  assign fire       = s_valid && s_ready;
  assign phase_done = (col == CW'(N2 - 1)) && (row == RW'(ROWS - 1));

  weights_addr_gen #(
    .ROWS (ROWS),
    .COLS (N2)
  ) u_addr_gen (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (begin_load),
    .step     (fire),
    .row      (row),
    .col      (col),
    .phase    (phase),
    .is_final (is_final)
  );

`ifdef WEIGHTS_LOADER_CKSUM_EN
  logic [7:0] sum;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum <= '0;
    end else if (begin_load) begin
      sum <= '0;
    end else if (fire) begin
      sum <= sum + 8'(s_data);
    end
  end

  // The final word must be folded in before comparing against the sender's sum.
  assign cksum_ok = ((sum + 8'(s_data)) == cksum_in);
`else
  assign cksum_ok = 1'b1;
`endif

  // s_ready is registered alongside state so it never depends on s_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      s_ready       <= 1'b0;
      busy          <= 1'b0;
      weights_valid <= 1'b0;
      error         <= 1'b0;
    end else if (begin_load) begin
      state         <= LOAD_MAG;
      s_ready       <= 1'b1;
      busy          <= 1'b1;
      weights_valid <= 1'b0;
      error         <= 1'b0;
    end else if (fire) begin
      if (is_final && s_last && cksum_ok) begin
        state         <= DONE;
        s_ready       <= 1'b0;
        busy          <= 1'b0;
        weights_valid <= 1'b1;
      end else if (is_final || s_last) begin
        state         <= ERR;
        s_ready       <= 1'b0;
        busy          <= 1'b0;
        weights_valid <= 1'b0;
        error         <= 1'b1;
      end else if (phase_done && state == LOAD_MAG) begin
        state <= LOAD_POL;
      end else if (phase_done && state == LOAD_POL) begin
        state <= LOAD_N2;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      weights_n1_mag <= '0;
      weights_n1_pol <= '0;
      weights_n2     <= '0;
    end else if (fire) begin
      case (phase)
        PH_MAG:  weights_n1_mag[row][col] <= s_data;
        PH_POL:  weights_n1_pol[row][col] <= s_data;
        PH_N2:   weights_n2[col]          <= s_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weights_loader.sv
// Randomized self-checking bench for weights_loader against a word-index reference model.
module tb_weights_loader;
  import weights_pkg::*;

  localparam int N1  = DEF_N1;
  localparam int N2  = DEF_N2;
  localparam int W   = DEF_W_K;
  localparam int R   = N1 / 2;
  localparam int TOT = TOTAL_WORDS;

  logic                         clk;
  logic                         rstn;
  logic                         start;
  logic [W-1:0]                 s_data;
  logic                         s_valid;
  logic                         s_ready;
  logic                         s_last;
`ifdef WEIGHTS_LOADER_CKSUM_EN
  logic [7:0]                   cksum_in;
`endif
  logic [R-1:0][N2-1:0][W-1:0]  weights_n1_mag;
  logic [R-1:0][N2-1:0][W-1:0]  weights_n1_pol;
  logic [N2-1:0][W-1:0]         weights_n2;
  logic                         weights_valid;
  logic                         busy;
  logic                         error;

  weights_loader #(
    .N1  (N1),
    .N2  (N2),
    .W_K (W)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_last         (s_last),
`ifdef WEIGHTS_LOADER_CKSUM_EN
    .cksum_in       (cksum_in),
`endif
    .weights_n1_mag (weights_n1_mag),
    .weights_n1_pol (weights_n1_pol),
    .weights_n2     (weights_n2),
    .weights_valid  (weights_valid),
    .busy           (busy),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what every element should hold, and the stream being sent.
  int exp_mag [R][N2];
  int exp_pol [R][N2];
  int exp_n2  [N2];
  int vals    [TOT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < N2; c++) begin
        exp_mag[r][c] = 0;
        exp_pol[r][c] = 0;
      end
    for (int c = 0; c < N2; c++) exp_n2[c] = 0;
  endfunction

  function automatic void model_write(input int idx, input int v);
    int j;
    if (idx < R * N2) begin
      exp_mag[idx / N2][idx % N2] = v;
    end else if (idx < 2 * R * N2) begin
      j = idx - R * N2;
      exp_pol[j / N2][j % N2] = v;
    end else begin
      exp_n2[idx - 2 * R * N2] = v;
    end
  endfunction

  // mode 0: index mod 16, mode 1: random, mode 2: all ones
  function automatic void gen_stream(input int mode);
    for (int i = 0; i < TOT; i++) begin
      case (mode)
        0:       vals[i] = i % 16;
        1:       vals[i] = int'($urandom_range(0, 15));
        default: vals[i] = 1;
      endcase
    end
  endfunction

  task automatic set_good_cksum();
`ifdef WEIGHTS_LOADER_CKSUM_EN
    int s = 0;
    for (int i = 0; i < TOT; i++) s += vals[i];
    cksum_in = 8'(s);
`endif
  endtask

  task automatic check_arrays(input string tag);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < N2; c++) begin
        check($sformatf("%s mag[%0d][%0d]", tag, r, c), 32'(weights_n1_mag[r][c]), exp_mag[r][c]);
        check($sformatf("%s pol[%0d][%0d]", tag, r, c), 32'(weights_n1_pol[r][c]), exp_pol[r][c]);
      end
    for (int c = 0; c < N2; c++)
      check($sformatf("%s n2[%0d]", tag, c), 32'(weights_n2[c]), exp_n2[c]);
  endtask

  task automatic check_status(input string tag, input bit v, input bit b, input bit e, input bit rdy);
    check({tag, " weights_valid"}, 32'(weights_valid), 32'(v));
    check({tag, " busy"},          32'(busy),          32'(b));
    check({tag, " error"},         32'(error),         32'(e));
    check({tag, " s_ready"},       32'(s_ready),       32'(rdy));
  endtask

  // All drive tasks begin and end at a falling edge.
  task automatic do_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_status({tag, " after start"}, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit last, input int gap_pct);
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      s_valid = 1'b0;
      s_data  = W'($urandom_range(0, 15));
      @(negedge clk);
    end
    check("s_ready in load", 32'(s_ready), 32'd1);
    check("busy in load",    32'(busy),    32'd1);
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_stream(input int n, input int last_idx, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      send_word(W'(vals[i]), (i == last_idx), gap_pct);
      model_write(i, vals[i]);
    end
  endtask

  task automatic idle_traffic(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      s_data  = W'($urandom_range(0, 15));
      s_valid = 1'b1;
      s_last  = 1'(i & 1);
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    rstn    = 1'b0;
    start   = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
`ifdef WEIGHTS_LOADER_CKSUM_EN
    cksum_in = '0;
`endif
    model_clear();

    #12;
    check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_arrays("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    idle_traffic(4);
    check_status("idle traffic", 1'b0, 1'b0, 1'b0, 1'b0);
    check_arrays("idle traffic");

    // Full continuous load with index-mod-16 data.
    gen_stream(0);
    set_good_cksum();
    do_start("full");
    send_stream(TOT, TOT - 1, 0);
    check_status("full done", 1'b1, 1'b0, 1'b0, 1'b0);
    check("full mag[0][0]",  32'(weights_n1_mag[0][0]),  32'd0);
    check("full mag[48][9]", 32'(weights_n1_mag[48][9]), 32'd9);
    check("full pol[0][0]",  32'(weights_n1_pol[0][0]),  32'd10);
    check("full n2[9]",      32'(weights_n2[9]),         32'((TOT - 1) % 16));
    check_arrays("full");

    idle_traffic(5);
    check_status("done traffic", 1'b1, 1'b0, 1'b0, 1'b0);
    check_arrays("done traffic");

    // Start and s_valid together in DONE: start wins, the word is dropped.
    gen_stream(1);
    set_good_cksum();
    s_data  = W'(~vals[0]);
    s_valid = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b0;
    check_status("bp start", 1'b0, 1'b1, 1'b0, 1'b1);
    check("bp mag[0][0] kept", 32'(weights_n1_mag[0][0]), exp_mag[0][0]);
    send_stream(TOT, TOT - 1, 40);
    check_status("bp done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_arrays("bp");

    // Early s_last on word 500 (pol[1][0]); pol[1][1] must keep its old value.
    gen_stream(1);
    vals[501] = (exp_pol[1][1] + 1) % 16;
    set_good_cksum();
    do_start("early");
    send_stream(501, 500, 20);
    check_status("early err", 1'b0, 1'b0, 1'b1, 1'b0);
    check("early pol[1][0]", 32'(weights_n1_pol[1][0]), 32'(vals[500]));
    check("early pol[1][1]", 32'(weights_n1_pol[1][1]), exp_pol[1][1]);
    check_arrays("early");
    idle_traffic(3);
    check_status("err traffic", 1'b0, 1'b0, 1'b1, 1'b0);
    check_arrays("err traffic");

    // Missing s_last on the final word, then recovery.
    gen_stream(0);
    set_good_cksum();
    do_start("nolast");
    send_stream(TOT, -1, 0);
    check_status("nolast err", 1'b0, 1'b0, 1'b1, 1'b0);
    check_arrays("nolast");
    gen_stream(1);
    set_good_cksum();
    do_start("recover");
    send_stream(TOT, TOT - 1, 10);
    check_status("recover done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_arrays("recover");

    // Asynchronous reset in the middle of a load.
    gen_stream(1);
    set_good_cksum();
    do_start("midrst");
    send_stream(300, -1, 0);
    #2 rstn = 1'b0;
    #1;
    model_clear();
    check_status("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_arrays("midrst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    gen_stream(0);
    set_good_cksum();
    do_start("reload");
    send_stream(TOT, TOT - 1, 15);
    check_status("reload done", 1'b1, 1'b0, 1'b0, 1'b0);
    check_arrays("reload");

`ifdef WEIGHTS_LOADER_CKSUM_EN
    gen_stream(2);
    cksum_in = 8'hDE;
    do_start("cksum good");
    send_stream(TOT, TOT - 1, 0);
    check_status("cksum good", 1'b1, 1'b0, 1'b0, 1'b0);
    check_arrays("cksum good");
    cksum_in = 8'hDF;
    do_start("cksum bad");
    send_stream(TOT, TOT - 1, 0);
    check_status("cksum bad", 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
